mem_master: RTL and testbench
=============================

MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bus data width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 4, word address width (AW); memory depth is 2^AW words.
REQ-003 SHALL have port iClk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port iReset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port iStart  input  1  one-cycle command strobe, sampled only in IDLE.
REQ-006 SHALL have port iOp  input  2  command: 00 FILL, 01 COPY, 10 CHECKSUM, 11 reserved.
REQ-007 SHALL have ports iSrcAddr  input  AW  source start address; iDstAddr  input  AW  destination start address.
REQ-008 SHALL have port iLength  input  AW+1  word count, 0..2^AW.
REQ-009 SHALL have port iFillData  input  DATA_WIDTH  FILL pattern.
REQ-010 SHALL have ports oBusy  output  1  command in progress; oDone  output  1  one-cycle completion pulse; oError  output  1  reserved-op flag, valid with oDone.
REQ-011 SHALL have port oResult  output  DATA_WIDTH  CHECKSUM result, held until next command.
REQ-012 SHALL have bus ports oChipSelect_n, oRead_n, oWrite_n  output  1 each  active-low strobes; oAddress  output  AW; oData  output  DATA_WIDTH  write data; iData  input  DATA_WIDTH  read data.

Function
REQ-013 SHALL latch iOp, addresses, iLength and iFillData on the edge where iStart=1 in IDLE; iStart SHALL be ignored when oBusy=1.
REQ-014 SHALL implement states IDLE, FILL_WR, CP_RD, CP_WR, CS_RD, CS_ACC, DONE; oBusy=1 in all states except IDLE.
REQ-015 SHALL treat read latency as: address captured at the edge closing a read cycle; iData valid throughout the following cycle.
REQ-016 FILL SHALL spend one FILL_WR cycle per word: oChipSelect_n=0, oWrite_n=0, oAddress=dst, oData=fill pattern.
REQ-017 COPY SHALL alternate CP_RD (CS_n=0, Read_n=0, oAddress=src) and CP_WR (CS_n=0, Write_n=0, oAddress=dst, oData=iData), 2 cycles per word.
REQ-018 CHECKSUM SHALL alternate CS_RD (read src) and CS_ACC (strobes idle, sum += iData modulo 2^DATA_WIDTH), 2 cycles per word; sum cleared at command accept.
REQ-019 Addresses SHALL increment by 1 per word and wrap modulo 2^AW; src/dst overlap is not detected.
REQ-020 Outside active read/write cycles all strobes SHALL be 1, oAddress and oData 0.
REQ-021 iLength=0 or reserved op SHALL go IDLE->DONE directly with no bus cycles; oError=1 only for reserved op.
REQ-022 DONE SHALL last exactly one cycle with oDone=1, then IDLE; oDone ends the cycle after the last bus/accumulate cycle.
REQ-023 A new iStart SHALL be accepted in the IDLE cycle right after DONE.

Reset
REQ-024 iReset=1 SHALL, at the next edge, force IDLE from any state, abort any command, and set oBusy=0, oDone=0, oError=0, oResult=0, strobes=1, oAddress=0, oData=0.
REQ-025 iReset SHALL take priority over iStart in the same cycle.

Configuration
REQ-026 Macro MEM_MASTER_CHECKSUM_EN SHALL, when defined, include CHECKSUM (CS_RD, CS_ACC, accumulator).
REQ-027 Without MEM_MASTER_CHECKSUM_EN, op 10 SHALL behave as reserved (immediate DONE, oError=1) and oResult SHALL be constant 0.

Verification
REQ-028 FILL dst=2, len=3, pattern=0xA5A5A5A5 -> writes at addresses 2,3,4 in 3 consecutive cycles; oDone in 4th cycle; memory words 2..4 read back 0xA5A5A5A5.
REQ-029 COPY src=0, dst=8, len=4, mem[0..3]=1,2,3,4 -> 8 bus cycles R/W alternating; mem[8..11]=1,2,3,4; oDone 9th cycle.
REQ-030 CHECKSUM src=14, len=4, mem[14,15,0,1]=0xFFFFFFFF,1,5,6 (MEM_MASTER_CHECKSUM_EN defined) -> reads wrap 14,15,0,1; oResult=0x0000000B.
REQ-031 len=0 and op=11 -> no strobes asserted; oDone next cycle; oError=0 and 1 respectively; same op=10 with macro undefined -> oError=1.
REQ-032 iReset asserted during 2nd word of COPY len=4 -> next cycle IDLE, strobes=1, oBusy=0, no oDone; fresh iStart accepted afterwards.
REQ-033 iStart pulsed while oBusy=1 -> ignored; running command completes unchanged.

Source files
------------

// File: rtl/mem_master.sv
// Memory bus master: FILL, COPY and optional CHECKSUM over a single-port SRAM-style bus.
// Define MEM_MASTER_CHECKSUM_EN to build the CHECKSUM engine; otherwise op 10 is reported as reserved.
module mem_master #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                     iClk,
  input  logic                     iReset,
  input  logic                     iStart,
  input  logic [1:0]               iOp,
  input  logic [ADDRESS_WIDTH-1:0] iSrcAddr,
  input  logic [ADDRESS_WIDTH-1:0] iDstAddr,
  input  logic [ADDRESS_WIDTH:0]   iLength,
  input  logic [DATA_WIDTH-1:0]    iFillData,
  output logic                     oBusy,
  output logic                     oDone,
  output logic                     oError,
  output logic [DATA_WIDTH-1:0]    oResult,
  output logic                     oChipSelect_n,
  output logic                     oRead_n,
  output logic                     oWrite_n,
  output logic [ADDRESS_WIDTH-1:0] oAddress,
  output logic [DATA_WIDTH-1:0]    oData,
  input  logic [DATA_WIDTH-1:0]    iData,
  output logic [2:0]               dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL_WR = 3'd1,
    CP_RD   = 3'd2,
    CP_WR   = 3'd3,
    CS_RD   = 3'd4,
    CS_ACC  = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t                     state;
  logic [ADDRESS_WIDTH-1:0]   src_q;
  logic [ADDRESS_WIDTH-1:0]   dst_q;
  logic [ADDRESS_WIDTH:0]     remaining_q;
  logic [DATA_WIDTH-1:0]      fill_q;
  logic [DATA_WIDTH-1:0]      data_q;
  logic                       pass_q;
  logic                       busy_q;
  logic                       done_q;
  logic                       error_q;
  logic                       cs_n_q;
  logic                       rd_n_q;
  logic                       wr_n_q;
  logic [ADDRESS_WIDTH-1:0]   addr_q;
  logic                       op_reserved;

`ifdef MEM_MASTER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]      sum_q;
  assign op_reserved = (iOp == 2'b11);
  assign oResult     = sum_q;
`else
  assign op_reserved = iOp[1];
  assign oResult     = '0;
`endif

  // Command handshake: iStart is taken only while IDLE (oBusy=0); oDone pulses
  // for exactly one cycle when the command retires, with oError qualified by it.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      state       <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      remaining_q <= '0;
      fill_q      <= '0;
      data_q      <= '0;
      pass_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      addr_q      <= '0;
`ifdef MEM_MASTER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      // Bus is parked every cycle unless a state below claims it.
      cs_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      addr_q  <= '0;
      data_q  <= '0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state)
        IDLE: begin
          if (iStart) begin
            src_q       <= iSrcAddr;
            dst_q       <= iDstAddr;
            fill_q      <= iFillData;
            remaining_q <= iLength - 1'b1;
            busy_q      <= 1'b1;
`ifdef MEM_MASTER_CHECKSUM_EN
            sum_q       <= '0;
`endif
            if (op_reserved || (iLength == '0)) begin
              state   <= DONE;
              done_q  <= 1'b1;
              error_q <= op_reserved;
            end else if (iOp == 2'b00) begin
              state  <= FILL_WR;
              cs_n_q <= 1'b0;
              wr_n_q <= 1'b0;
              addr_q <= iDstAddr;
              data_q <= iFillData;
              dst_q  <= iDstAddr + 1'b1;
            end else if (iOp == 2'b01) begin
              state  <= CP_RD;
              cs_n_q <= 1'b0;
              rd_n_q <= 1'b0;
              addr_q <= iSrcAddr;
              src_q  <= iSrcAddr + 1'b1;
            end else begin
`ifdef MEM_MASTER_CHECKSUM_EN
              state  <= CS_RD;
              cs_n_q <= 1'b0;
              rd_n_q <= 1'b0;
              addr_q <= iSrcAddr;
              src_q  <= iSrcAddr + 1'b1;
`else
              state  <= DONE;
              done_q <= 1'b1;
`endif
            end
          end
        end
        FILL_WR: begin
          if (remaining_q == '0) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            cs_n_q      <= 1'b0;
            wr_n_q      <= 1'b0;
            addr_q      <= dst_q;
            data_q      <= fill_q;
            dst_q       <= dst_q + 1'b1;
            remaining_q <= remaining_q - 1'b1;
          end
        end
        CP_RD: begin
          // Write data is the read word, forwarded from iData during CP_WR.
          state  <= CP_WR;
          cs_n_q <= 1'b0;
          wr_n_q <= 1'b0;
          addr_q <= dst_q;
          pass_q <= 1'b1;
          dst_q  <= dst_q + 1'b1;
        end
        CP_WR: begin
          if (remaining_q == '0) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            state       <= CP_RD;
            cs_n_q      <= 1'b0;
            rd_n_q      <= 1'b0;
            addr_q      <= src_q;
            src_q       <= src_q + 1'b1;
            remaining_q <= remaining_q - 1'b1;
          end
        end
`ifdef MEM_MASTER_CHECKSUM_EN
        CS_RD: begin
          state <= CS_ACC;
        end
        CS_ACC: begin
          sum_q <= sum_q + iData;
          if (remaining_q == '0) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            state       <= CS_RD;
            cs_n_q      <= 1'b0;
            rd_n_q      <= 1'b0;
            addr_q      <= src_q;
            src_q       <= src_q + 1'b1;
            remaining_q <= remaining_q - 1'b1;
          end
        end
`endif
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign oBusy         = busy_q;
  assign oDone         = done_q;
  assign oError        = error_q;
  assign oChipSelect_n = cs_n_q;
  assign oRead_n       = rd_n_q;
  assign oWrite_n      = wr_n_q;
  assign oAddress      = addr_q;
  assign oData         = pass_q ? iData : data_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_mem_master.sv
// Testbench for mem_master: SRAM slave model, per-cycle bus trace scoreboard and memory image model.
// Honours MEM_MASTER_CHECKSUM_EN the same way the design does.
module tb_mem_master;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int TW    = DW + AW + 5;
  localparam logic [1:0] K_IDLE = 2'd0;
  localparam logic [1:0] K_RD   = 2'd1;
  localparam logic [1:0] K_WR   = 2'd2;
  localparam logic [1:0] K_BAD  = 2'd3;
`ifdef MEM_MASTER_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic          iClk;
  logic          iReset;
  logic          iStart;
  logic [1:0]    iOp;
  logic [AW-1:0] iSrcAddr;
  logic [AW-1:0] iDstAddr;
  logic [AW:0]   iLength;
  logic [DW-1:0] iFillData;
  logic          oBusy;
  logic          oDone;
  logic          oError;
  logic [DW-1:0] oResult;
  logic          oChipSelect_n;
  logic          oRead_n;
  logic          oWrite_n;
  logic [AW-1:0] oAddress;
  logic [DW-1:0] oData;
  logic [DW-1:0] iData;
  logic [2:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [TW-1:0] exp_q[$];
  logic [DW-1:0] ref_mem [DEPTH];

  mem_master #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .iClk(iClk), .iReset(iReset), .iStart(iStart), .iOp(iOp),
    .iSrcAddr(iSrcAddr), .iDstAddr(iDstAddr), .iLength(iLength), .iFillData(iFillData),
    .oBusy(oBusy), .oDone(oDone), .oError(oError), .oResult(oResult),
    .oChipSelect_n(oChipSelect_n), .oRead_n(oRead_n), .oWrite_n(oWrite_n),
    .oAddress(oAddress), .oData(oData), .iData(iData), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // SRAM slave: address captured at the edge closing a read cycle, data held next cycle.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_data;
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  always @(posedge iClk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (!oChipSelect_n && !oWrite_n) mem[oAddress] <= oData;
    if (!oChipSelect_n && !oRead_n) rd_data <= mem[oAddress];
  end
  assign iData = rd_data;

  function automatic logic [TW-1:0] ent(input logic b, input logic d, input logic e,
                                        input logic [1:0] k, input logic [AW-1:0] a,
                                        input logic [DW-1:0] dt);
    return {b, d, e, k, a, dt};
  endfunction

  function automatic logic [TW-1:0] observe();
    logic [1:0] k;
    if (oChipSelect_n) k = (oRead_n && oWrite_n) ? K_IDLE : K_BAD;
    else if (!oRead_n && oWrite_n) k = K_RD;
    else if (oRead_n && !oWrite_n) k = K_WR;
    else k = K_BAD;
    return ent(oBusy, oDone, oError, k, oAddress, (k == K_RD) ? '0 : oData);
  endfunction

  // Driver tasks
  task automatic preload_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge iClk);
    pl_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic check_idle(input string name);
    logic [TW-1:0] obs;
    obs = observe();
    n_checks++;
    if (obs !== ent(1'b0, 1'b0, 1'b0, K_IDLE, '0, '0)) begin
      n_fail++;
      $display("FAIL %s idle: got %h expected %h", name, obs, ent(1'b0, 1'b0, 1'b0, K_IDLE, '0, '0));
    end
  endtask

  task automatic check_mem(input string name);
    for (int k = 0; k < DEPTH; k++) begin
      n_checks++;
      if (mem[k] !== ref_mem[k]) begin
        n_fail++;
        $display("FAIL %s mem[%0d]: got %h expected %h", name, k, mem[k], ref_mem[k]);
      end
    end
  endtask

  // Builds the expected per-cycle trace from the command semantics, runs it, then
  // checks the idle cycle after DONE, the result and the whole memory image.
  task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                         input logic [AW:0] len, input logic [DW-1:0] fill, input int pulse_at,
                         input string name);
    logic          reserved;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [DW-1:0] v;
    logic [DW-1:0] sum;
    logic [TW-1:0] obs;
    logic [TW-1:0] exp;
    int            cyc;
    reserved = (op == 2'b11) || (op == 2'b10 && !CS_EN);
    sum = '0;
    exp_q.delete();
    if (reserved || len == 0) begin
      exp_q.push_back(ent(1'b1, 1'b1, reserved, K_IDLE, '0, '0));
    end else begin
      for (int i = 0; i < int'(len); i++) begin
        a = src + AW'(i);
        b = dst + AW'(i);
        case (op)
          2'b00: begin
            exp_q.push_back(ent(1'b1, 1'b0, 1'b0, K_WR, b, fill));
            ref_mem[b] = fill;
          end
          2'b01: begin
            v = ref_mem[a];
            exp_q.push_back(ent(1'b1, 1'b0, 1'b0, K_RD, a, '0));
            exp_q.push_back(ent(1'b1, 1'b0, 1'b0, K_WR, b, v));
            ref_mem[b] = v;
          end
          default: begin
            exp_q.push_back(ent(1'b1, 1'b0, 1'b0, K_RD, a, '0));
            exp_q.push_back(ent(1'b1, 1'b0, 1'b0, K_IDLE, '0, '0));
            sum = sum + ref_mem[a];
          end
        endcase
      end
      exp_q.push_back(ent(1'b1, 1'b1, 1'b0, K_IDLE, '0, '0));
    end
    iOp = op; iSrcAddr = src; iDstAddr = dst; iLength = len; iFillData = fill;
    iStart = 1'b1;
    @(posedge iClk);
    #1;
    iStart = 1'b0;
    // Scramble command inputs to prove they were latched.
    iOp = 2'($urandom); iSrcAddr = AW'($urandom); iDstAddr = AW'($urandom);
    iLength = (AW+1)'($urandom_range(0, DEPTH)); iFillData = $urandom;
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(negedge iClk);
      cyc++;
      iStart = 1'b0;
      obs = observe();
      exp = exp_q.pop_front();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, obs, exp);
      end
      if (cyc == pulse_at) begin
        iStart = 1'b1; iOp = 2'b01; iSrcAddr = AW'($urandom); iDstAddr = AW'($urandom);
        iLength = (AW+1)'(DEPTH); iFillData = $urandom;
      end
    end
    iStart = 1'b0;
    @(negedge iClk);
    check_idle(name);
    n_checks++;
    if (oResult !== sum) begin
      n_fail++;
      $display("FAIL %s result: got %h expected %h", name, oResult, sum);
    end
    check_mem(name);
  endtask

  task automatic test_reset();
    logic [TW-1:0] obs;
    iReset = 1'b1; iStart = 1'b0; iOp = '0; iSrcAddr = '0; iDstAddr = '0;
    iLength = '0; iFillData = '0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (3) @(negedge iClk);
    check_idle("reset");
    n_checks++;
    if (oResult !== '0) begin
      n_fail++;
      $display("FAIL reset result: got %h expected 0", oResult);
    end
    iReset = 1'b0;
    for (int k = 0; k < DEPTH; k++) preload_word(AW'(k), $urandom);
    // Reset wins over a same-cycle start.
    iReset = 1'b1; iStart = 1'b1; iOp = 2'b00; iDstAddr = '0; iLength = 5'd5; iFillData = 32'hDEADBEEF;
    @(negedge iClk);
    iReset = 1'b0; iStart = 1'b0;
    check_idle("reset_vs_start");
    @(negedge iClk);
    obs = observe();
    n_checks++;
    if (obs[TW-1] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_vs_start busy: got %b expected 0", obs[TW-1]);
    end
    check_mem("reset_vs_start");
  endtask

  task automatic test_fill();
    run_cmd(2'b00, 4'd0, 4'd2, 5'd3, 32'hA5A5A5A5, 0, "fill");
  endtask

  task automatic test_copy();
    for (int k = 0; k < 4; k++) preload_word(AW'(k), DW'(k + 1));
    run_cmd(2'b01, 4'd0, 4'd8, 5'd4, '0, 0, "copy");
  endtask

  task automatic test_checksum();
    preload_word(4'd14, 32'hFFFFFFFF);
    preload_word(4'd15, 32'h1);
    preload_word(4'd0, 32'h5);
    preload_word(4'd1, 32'h6);
    run_cmd(2'b10, 4'd14, 4'd0, 5'd4, '0, 0, "checksum");
    if (CS_EN) begin
      run_cmd(2'b10, 4'd14, 4'd0, 5'd4, '0, 0, "checksum_again");
    end
  endtask

  task automatic test_len_zero_reserved();
    run_cmd(2'b00, 4'd3, 4'd3, 5'd0, 32'h12345678, 0, "len_zero");
    run_cmd(2'b11, 4'd1, 4'd2, 5'd4, 32'h12345678, 0, "reserved_op");
    run_cmd(2'b01, 4'd5, 4'd6, 5'd0, '0, 0, "copy_len_zero");
  endtask

  task automatic test_reset_mid_copy();
    logic [TW-1:0] obs;
    for (int k = 0; k < 4; k++) preload_word(AW'(k), $urandom);
    iOp = 2'b01; iSrcAddr = 4'd0; iDstAddr = 4'd8; iLength = 5'd4; iFillData = '0;
    iStart = 1'b1;
    @(posedge iClk);
    #1;
    iStart = 1'b0;
    repeat (3) @(negedge iClk);
    iReset = 1'b1;
    @(negedge iClk);
    iReset = 1'b0;
    check_idle("reset_mid_copy");
    ref_mem[8] = ref_mem[0];
    for (int c = 0; c < 3; c++) begin
      @(negedge iClk);
      obs = observe();
      n_checks++;
      if (obs[TW-1:TW-2] !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_mid_copy busy/done: got %b expected 00", obs[TW-1:TW-2]);
      end
    end
    check_mem("reset_mid_copy");
    run_cmd(2'b00, 4'd0, 4'd12, 5'd2, 32'h0BADF00D, 0, "after_reset");
  endtask

  task automatic test_busy_ignore();
    run_cmd(2'b00, 4'd0, 4'd5, 5'd4, 32'hCAFEF00D, 2, "busy_ignore");
  endtask

  task automatic test_back_to_back();
    run_cmd(2'b01, 4'd10, 4'd11, 5'd16, '0, 0, "b2b_full_wrap");
    run_cmd(2'b00, 4'd0, 4'd15, 5'd16, 32'h5A5A0F0F, 0, "b2b_fill_full");
    run_cmd(2'b10, 4'd7, 4'd0, 5'd1, '0, 0, "b2b_cs_one");
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      run_cmd(2'($urandom_range(0, 3)), AW'($urandom), AW'($urandom),
              (AW+1)'($urandom_range(0, DEPTH)), $urandom, 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_copy();
    test_checksum();
    test_len_zero_reserved();
    test_reset_mid_copy();
    test_busy_ignore();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
